// File: rtl/gb_timer.sv
// DMG-style DIV/TIMA/TMA/TAC timer with falling-edge tick detection and delayed TMA reload.
// Build option GB_TIMER_IRQ_LATCH_EN: irq_timer becomes a sticky flag cleared by irq_ack.
module gb_timer #(
    parameter logic [15:0] BASE_ADDR = 16'hFF04,
    parameter int unsigned OVF_DELAY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [7:0]  wr_data,
`ifdef GB_TIMER_IRQ_LATCH_EN
    input  logic        irq_ack,
`endif
    output logic [7:0]  rd_data,
    output logic        hit,
    output logic        irq_timer
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_OVF,
        ST_RELOAD
    } state_t;

    localparam int unsigned DW = (OVF_DELAY > 2) ? $clog2(OVF_DELAY) : 1;
    localparam logic [DW-1:0] DELAY_INIT = DW'(OVF_DELAY - 1);

    logic [15:0]   r_sys_cnt;
    logic [7:0]    r_tima;
    logic [7:0]    r_tma;
    logic [2:0]    r_tac;
    logic          r_tick_d;
    state_t        r_state;
    logic [DW-1:0] r_delay_cnt;
    logic [7:0]    r_rd_data;
    logic          r_hit;

    logic [15:0]   w_offset;
    logic          w_in_range;
    logic          w_wr_div;
    logic          w_wr_tima;
    logic          w_wr_tma;
    logic          w_wr_tac;
    logic          w_sel_bit;
    logic          w_tick_in;
    logic          w_fall;
    logic          w_reload;
    logic [7:0]    w_rd_mux;
    state_t        w_state_nxt;
    logic [7:0]    w_tima_nxt;
    logic [DW-1:0] w_delay_nxt;

    // Unsigned offset from the base: anything past +3 (or below base, which wraps) is out of range.
    assign w_offset   = addr - BASE_ADDR;
    assign w_in_range = (w_offset < 16'd4);
    assign w_wr_div   = wr_en && w_in_range && (w_offset[1:0] == 2'd0);
    assign w_wr_tima  = wr_en && w_in_range && (w_offset[1:0] == 2'd1);
    assign w_wr_tma   = wr_en && w_in_range && (w_offset[1:0] == 2'd2);
    assign w_wr_tac   = wr_en && w_in_range && (w_offset[1:0] == 2'd3);

    always_comb begin
        unique case (r_tac[1:0])
            2'b00:   w_sel_bit = r_sys_cnt[9];
            2'b01:   w_sel_bit = r_sys_cnt[3];
            2'b10:   w_sel_bit = r_sys_cnt[5];
            default: w_sel_bit = r_sys_cnt[7];
        endcase
    end

    // A falling edge of the gated tick, not the counter bit itself, clocks TIMA; this is what
    // makes DIV and TAC writes able to inject an extra increment.
    assign w_tick_in = r_tac[2] & w_sel_bit;
    assign w_fall    = r_tick_d & ~w_tick_in;
    assign w_reload  = (r_state == ST_RELOAD);

    always_comb begin
        w_rd_mux = 8'hFF;
        if (w_in_range) begin
            unique case (w_offset[1:0])
                2'd0:    w_rd_mux = r_sys_cnt[15:8];
                2'd1:    w_rd_mux = r_tima;
                2'd2:    w_rd_mux = r_tma;
                default: w_rd_mux = {5'b11111, r_tac};
            endcase
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_tima_nxt  = r_tima;
        w_delay_nxt = r_delay_cnt;
        unique case (r_state)
            ST_RUN: begin
                if (w_wr_tima) begin
                    w_tima_nxt = wr_data;
                end else if (w_fall) begin
                    if (r_tima == 8'hFF) begin
                        w_tima_nxt  = 8'h00;
                        w_delay_nxt = DELAY_INIT;
                        w_state_nxt = (OVF_DELAY > 1) ? ST_OVF : ST_RELOAD;
                    end else begin
                        w_tima_nxt = r_tima + 8'd1;
                    end
                end
            end
            ST_OVF: begin
                // RELOAD is the last zero-reading cycle, so OVF lasts OVF_DELAY-1 cycles.
                if (w_wr_tima) begin
                    w_tima_nxt  = wr_data;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_delay_nxt = r_delay_cnt - 1'b1;
                    if (w_delay_nxt == '0) begin
                        w_state_nxt = ST_RELOAD;
                    end
                end
            end
            ST_RELOAD: begin
                w_tima_nxt  = w_wr_tma ? wr_data : r_tma;
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sys_cnt   <= '0;
            r_tima      <= '0;
            r_tma       <= '0;
            r_tac       <= '0;
            r_tick_d    <= 1'b0;
            r_state     <= ST_RUN;
            r_delay_cnt <= '0;
            r_rd_data   <= '0;
            r_hit       <= 1'b0;
        end else begin
            r_sys_cnt   <= w_wr_div ? 16'd0 : r_sys_cnt + 16'd1;
            r_tick_d    <= w_tick_in;
            r_state     <= w_state_nxt;
            r_tima      <= w_tima_nxt;
            r_delay_cnt <= w_delay_nxt;
            if (w_wr_tma) begin
                r_tma <= wr_data;
            end
            if (w_wr_tac) begin
                r_tac <= wr_data[2:0];
            end
            if (rd_en) begin
                r_rd_data <= w_rd_mux;
                r_hit     <= w_in_range;
            end
        end
    end

    assign rd_data = r_rd_data;
    assign hit     = r_hit;

`ifdef GB_TIMER_IRQ_LATCH_EN
    logic r_irq_latch;

    // Setting on RELOAD takes priority over a coincident acknowledge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_latch <= 1'b0;
        end else if (w_reload) begin
            r_irq_latch <= 1'b1;
        end else if (irq_ack) begin
            r_irq_latch <= 1'b0;
        end
    end

    assign irq_timer = w_reload | r_irq_latch;
`else
    assign irq_timer = w_reload;
`endif

endmodule

// File: tb/tb_gb_timer.sv
// Directed self-checking bench for gb_timer: bus reads, DIV, overflow/reload FSM, tick quirks.
// Exercises the sticky interrupt when GB_TIMER_IRQ_LATCH_EN is defined.
module tb_gb_timer;

    localparam logic [15:0] BASE = 16'hFF04;
`ifdef GB_TIMER_IRQ_LATCH_EN
    localparam logic LATCH = 1'b1;
`else
    localparam logic LATCH = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addr = 16'h0000;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic [7:0]  rd_data;
    logic        hit;
    logic        irq_timer;
`ifdef GB_TIMER_IRQ_LATCH_EN
    logic        irq_ack = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    gb_timer dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .wr_data   (wr_data),
`ifdef GB_TIMER_IRQ_LATCH_EN
        .irq_ack   (irq_ack),
`endif
        .rd_data   (rd_data),
        .hit       (hit),
        .irq_timer (irq_timer)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Ends on the negedge right after the reset edge, where sys_cnt reads 0.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
`ifdef GB_TIMER_IRQ_LATCH_EN
        irq_ack = 1'b0;
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] off, input logic [7:0] d);
        addr = BASE + 16'(off); wr_data = d; wr_en = 1'b1; rd_en = 1'b0;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d, output logic h);
        addr = a; rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        d = rd_data; h = hit;
    endtask

    // TAC=0x05 (16-clk tick), TMA=0x10, TIMA=0xFE, then continuous TIMA reads.
    task automatic setup_ovf();
        do_reset();
        bus_write(2'd3, 8'h05);
        bus_write(2'd2, 8'h10);
        bus_write(2'd1, 8'hFE);
        addr = BASE + 16'd1; rd_en = 1'b1;
    endtask

    // Returns on the first sample reading 0x00 after 0xFF; period = samples spent at 0xFF.
    task automatic run_to_ovf(output logic ok, output int period);
        ok = 1'b0; period = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (rd_data === 8'hFF) begin ok = 1'b1; break; end
        end
        if (ok) begin
            ok = 1'b0;
            for (int i = 1; i <= 40; i++) begin
                @(negedge clk);
                if (rd_data !== 8'hFF) begin ok = 1'b1; period = i; break; end
            end
        end
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL ovf_reached: TIMA never went 0xFF -> next value within budget (last rd_data=%h)", rd_data);
        end
    endtask

    task automatic test_reset();
        logic [7:0] d; logic h;
        do_reset();
        n_checks++;
        if ({rd_data, hit, irq_timer} !== {8'h00, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_outputs: rd_data=%h hit=%b irq=%b, want 00 0 0", rd_data, hit, irq_timer);
        end
        bus_read(BASE + 16'd1, d, h);
        n_checks++;
        if ({d, h} !== {8'h00, 1'b1}) begin
            n_errors++; $display("FAIL reset_tima: got %h hit=%b, want 00 hit=1", d, h);
        end
        bus_read(BASE + 16'd2, d, h);
        n_checks++;
        if (d !== 8'h00) begin n_errors++; $display("FAIL reset_tma: got %h, want 00", d); end
        bus_read(BASE + 16'd3, d, h);
        n_checks++;
        if (d !== 8'hF8) begin n_errors++; $display("FAIL reset_tac: got %h, want F8", d); end
    endtask

    task automatic test_div();
        logic [7:0] d; logic h;
        do_reset();
        repeat (256) @(negedge clk);
        bus_read(BASE, d, h);
        n_checks++;
        if ({d, h} !== {8'h01, 1'b1}) begin
            n_errors++; $display("FAIL div_256: got %h hit=%b, want 01 hit=1", d, h);
        end
        bus_write(2'd0, 8'h5A);
        n_checks++;
        if (rd_data !== 8'h01) begin n_errors++; $display("FAIL rd_hold: got %h, want 01", rd_data); end
        bus_read(BASE, d, h);
        n_checks++;
        if (d !== 8'h00) begin n_errors++; $display("FAIL div_clear: got %h, want 00", d); end
        bus_read(BASE + 16'd4, d, h);
        n_checks++;
        if ({d, h} !== {8'hFF, 1'b0}) begin
            n_errors++; $display("FAIL oob_high: got %h hit=%b, want FF hit=0", d, h);
        end
        bus_read(BASE - 16'd1, d, h);
        n_checks++;
        if ({d, h} !== {8'hFF, 1'b0}) begin
            n_errors++; $display("FAIL oob_low: got %h hit=%b, want FF hit=0", d, h);
        end
    endtask

    task automatic test_overflow();
        logic ok; int period;
        logic [7:0] exp_rd  [5] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h10};
        logic       exp_irq [5] = '{1'b0, 1'b0, 1'b1, LATCH, LATCH};
        setup_ovf();
        run_to_ovf(ok, period);
        n_checks++;
        if (period != 16) begin n_errors++; $display("FAIL tick_period: got %0d, want 16", period); end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if ({rd_data, irq_timer} !== {exp_rd[i], exp_irq[i]}) begin
                n_errors++;
                $display("FAIL ovf_seq[%0d]: tima=%h irq=%b, want %h %b",
                         i, rd_data, irq_timer, exp_rd[i], exp_irq[i]);
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_ovf_write();
        logic ok; int period; logic saw_irq;
        setup_ovf();
        run_to_ovf(ok, period);
        saw_irq = irq_timer;
        wr_data = 8'h33; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; saw_irq |= irq_timer;
        @(negedge clk);
        saw_irq |= irq_timer;
        n_checks++;
        if (rd_data !== 8'h33) begin n_errors++; $display("FAIL ovf_write: got %h, want 33", rd_data); end
        repeat (4) begin @(negedge clk); saw_irq |= irq_timer; end
        n_checks++;
        if ({rd_data, saw_irq} !== {8'h33, 1'b0}) begin
            n_errors++;
            $display("FAIL ovf_cancel: tima=%h irq_seen=%b, want 33 0", rd_data, saw_irq);
        end
        rd_en = 1'b0;
    endtask

    task automatic test_reload_writes();
        logic ok; int period;
        setup_ovf();
        run_to_ovf(ok, period);
        repeat (2) @(negedge clk);
        n_checks++;
        if (irq_timer !== 1'b1) begin n_errors++; $display("FAIL reload_irq_tma: got %b, want 1", irq_timer); end
        rd_en = 1'b0; addr = BASE + 16'd2; wr_data = 8'h77; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; addr = BASE + 16'd1; rd_en = 1'b1;
        @(negedge clk);
        n_checks++;
        if (rd_data !== 8'h77) begin n_errors++; $display("FAIL reload_tma_write: got %h, want 77", rd_data); end
        rd_en = 1'b0;

        setup_ovf();
        run_to_ovf(ok, period);
        repeat (2) @(negedge clk);
        n_checks++;
        if (irq_timer !== 1'b1) begin n_errors++; $display("FAIL reload_irq_tima: got %b, want 1", irq_timer); end
        wr_data = 8'h44; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rd_data !== 8'h10) begin n_errors++; $display("FAIL reload_tima_ignored: got %h, want 10", rd_data); end
        rd_en = 1'b0;
    endtask

    // sys_cnt is tracked by negedge count from reset (0 right after do_reset).
    task automatic test_tick_quirks();
        logic [7:0] d; logic h;
        do_reset();
        bus_write(2'd3, 8'h05);            // sys_cnt now 1
        repeat (9) @(negedge clk);         // sys_cnt 10: bit3=1
        bus_write(2'd0, 8'h00);            // DIV cleared -> falling edge
        @(negedge clk);
        bus_read(BASE + 16'd1, d, h);
        n_checks++;
        if (d !== 8'h01) begin n_errors++; $display("FAIL div_write_tick: got %h, want 01", d); end
        repeat (8) @(negedge clk);         // sys_cnt 10 again
        bus_write(2'd3, 8'h01);            // disable while tick_in=1
        @(negedge clk);
        bus_read(BASE + 16'd1, d, h);
        n_checks++;
        if (d !== 8'h02) begin n_errors++; $display("FAIL tac_write_tick: got %h, want 02", d); end
        bus_read(BASE + 16'd3, d, h);
        n_checks++;
        if (d !== 8'hF9) begin n_errors++; $display("FAIL tac_read: got %h, want F9", d); end
        repeat (40) @(negedge clk);
        bus_read(BASE + 16'd1, d, h);
        n_checks++;
        if (d !== 8'h02) begin n_errors++; $display("FAIL disabled_hold: got %h, want 02", d); end
    endtask

`ifdef GB_TIMER_IRQ_LATCH_EN
    task automatic test_irq_latch();
        logic ok; int period;
        setup_ovf();
        run_to_ovf(ok, period);
        repeat (8) @(negedge clk);
        n_checks++;
        if (irq_timer !== 1'b1) begin n_errors++; $display("FAIL latch_hold: got %b, want 1", irq_timer); end
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        n_checks++;
        if (irq_timer !== 1'b0) begin n_errors++; $display("FAIL latch_ack: got %b, want 0", irq_timer); end

        setup_ovf();
        run_to_ovf(ok, period);
        repeat (2) @(negedge clk);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        n_checks++;
        if (irq_timer !== 1'b1) begin n_errors++; $display("FAIL latch_set_wins: got %b, want 1", irq_timer); end
        rd_en = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_div();
        test_overflow();
        test_ovf_write();
        test_reload_writes();
        test_tick_quirks();
`ifdef GB_TIMER_IRQ_LATCH_EN
        test_irq_latch();
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
